// File: rtl/instruction_fetch_unit_if.sv
// Bundles the program-memory request/response channel and the decode-side
// instruction channel seen by the fetch unit.
interface instruction_fetch_unit_if #(
  parameter int PC_W = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [PC_W-1:0] imem_resp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] instr_out;
  logic [PC_W-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues word-addressed requests under a credit
// limit, queues responses with their PCs and drops stale ones after a redirect.
module instruction_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PC_W-1:0]         initial_pc,
  input  logic                    fetch_enable,
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_pc,
  instruction_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drain_q, drain_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [PC_W-1:0] mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];

  logic [CW+1:0] credit_used;
  logic          req_valid;
  logic          accept;
  logic          resp_stale;
  logic          resp_good;
  logic          push;
  logic          pop;

  always_comb begin
    credit_used = {2'b00, count_q} + {2'b00, outstanding_q} + {2'b00, drain_q};
    req_valid   = !reset && fetch_enable && !redirect_valid
                  && (credit_used < (CW+2)'(DEPTH));
    accept      = req_valid && bus.imem_req_ready;
    resp_stale  = bus.imem_resp_valid && (drain_q != '0);
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_good   = bus.imem_resp_valid && (drain_q == '0) && (outstanding_q != '0);
    push        = resp_good && !redirect_valid;
    pop         = (count_q != '0) && bus.instr_ready;

    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drain_d       = drain_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect_valid) begin
      // Everything still in flight becomes stale; a good response landing
      // this very cycle is dropped here and therefore needs no drain slot.
      fetch_pc_d    = redirect_pc;
      resp_pc_d     = redirect_pc;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = '0;
      drain_d       = drain_q + outstanding_q - CW'(resp_stale) - CW'(resp_good);
    end else begin
      fetch_pc_d    = fetch_pc_q + PC_W'(accept);
      outstanding_d = outstanding_q + CW'(accept) - CW'(resp_good);
      drain_d       = drain_q - CW'(resp_stale);
      resp_pc_d     = resp_pc_q + PC_W'(push);
      count_d       = count_q + CW'(push) - CW'(pop);
      wr_ptr_d      = wr_ptr_q + AW'(push);
      rd_ptr_d      = rd_ptr_q + AW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= initial_pc;
      resp_pc_q     <= initial_pc;
      count_q       <= '0;
      outstanding_q <= '0;
      drain_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drain_q       <= drain_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= bus.imem_resp_data;
      mem_pc[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // Head is masked while empty so outputs read zero straight out of reset.
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.instr_valid    = (count_q != '0);
  assign bus.instr_out      = (count_q != '0) ? mem_instr[rd_ptr_q] : '0;
  assign bus.instr_pc       = (count_q != '0) ? mem_pc[rd_ptr_q] : '0;
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end stage directly upstream of the single-cycle processor's decode/execute.
- Owns the PC and issues word-addressed fetch requests to program memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush and discard of in-flight stale responses.

Parameters:
DEPTH, 4, FIFO entries; also the cap on (FIFO occupancy + outstanding requests); power of two, >= 2
PC_W, 32, PC and instruction width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
initial_pc  input  PC_W  PC value loaded on reset
fetch_enable  input  1  when 0, no new requests issued; in-flight responses still accepted
redirect_valid  input  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  input  PC_W  new fetch PC
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  PC_W  word address of request (= fetch_pc)
imem_resp_valid  input  1  response valid; responses return in request order, no backpressure
imem_resp_data  input  PC_W  returned instruction word
instr_valid  output  1  FIFO non-empty
instr_ready  input  1  decode consumes head entry
instr_out  output  PC_W  head instruction
instr_pc  output  PC_W  PC of head instruction

Behaviour:
- Reset (async, active-high):
  - fetch_pc = resp_pc = initial_pc.
  - FIFO empty; outstanding = 0; drain = 0.
  - imem_req_valid = 0, instr_valid = 0, instr_out = 0, instr_pc = 0.
  - Reset mid-operation discards everything; responses arriving after deassertion with outstanding = 0 are ignored.
- PC is word-addressed: increments by 1 per accepted request, wrapping mod 2^PC_W.
- Request issue:
  - imem_req_valid = fetch_enable && !redirect_valid && (count + outstanding + drain < DEPTH).
  - imem_addr = fetch_pc.
  - On accept (imem_req_valid && imem_req_ready): fetch_pc += 1 and outstanding += 1.
- Response handling, when imem_resp_valid:
  - If drain > 0: the response is stale. Drop it and decrement drain.
  - Otherwise: push {resp_pc, imem_resp_data} into the FIFO, resp_pc += 1, outstanding -= 1.
- Credit rule guarantees a push never meets a full FIFO. A response with outstanding = 0 and drain = 0 is a protocol error: ignore it.
- Output side:
  - instr_valid = (count != 0); instr_out and instr_pc show the head entry, registered FIFO storage.
  - Pop on instr_valid && instr_ready.
  - Minimum latency: response at edge N gives instr_valid high after edge N+1. No bypass.
- Simultaneous push and pop: count unchanged; legal when full (pop frees the slot in the same cycle).
- Redirect (redirect_valid high at an edge):
  - fetch_pc = resp_pc = redirect_pc.
  - FIFO flushed to count = 0.
  - drain += outstanding; outstanding = 0. Also account for a non-stale response in the same cycle: it is dropped, and that slot is not added to drain.
  - No request is issued in the redirect cycle.
- Redirect and pop in the same cycle: the popped entry counts as consumed by decode; the rest is flushed.
- Back-to-back redirects: the last one wins; drain accumulates correctly.
- Counters: count, outstanding and drain are each log2(DEPTH)+1 bits; their sum never exceeds DEPTH.
- State summary:
  - RUN: drain = 0.
  - DRAIN: drain > 0; requests are still allowed within credit.
  - Transitions are implicit via drain.

Test Plan:
- Reset with initial_pc=0x100, fetch_enable=1, memory 1-cycle latency returning data=addr^0xFFFF_0000, instr_ready=1 → instr_pc sequence 0x100, 0x101, 0x102…; instr_out matches; first instr_valid 2 cycles after first request accept.
- instr_ready=0 held, DEPTH=4 → exactly 4 requests accepted (addresses 0x100–0x103), then imem_req_valid=0. Release instr_ready → 4 entries drain in order; issue resumes at 0x104.
- Memory latency 3, 3 requests outstanding, redirect_pc=0x200 → next 3 responses dropped, FIFO empty, first delivered instr_pc=0x200 with correct data.
- Redirect in the same cycle as a pop of head 0x105 with 2 entries queued → 0x105 consumed once; 0x106 never appears; next instr_pc=redirect_pc.
- fetch_enable=0 with 2 outstanding → both responses enqueued, no new requests; re-enable → resumes at the correct fetch_pc.
- Assert reset mid-stream with 2 outstanding and FIFO holding 3 entries → outputs 0 immediately (asynchronous); after release, fetch restarts at initial_pc; late responses ignored.
